// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces from the miner and ships each one over an 8N1 UART line.
// Each nonce goes out as four bytes, most significant byte first, with each byte sent LSB first.
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_LOG2    = 2
) (
  input  logic                 hash_clk,
  input  logic                 rst_n,
  input  logic                 golden_valid_i,
  input  logic [31:0]          golden_nonce_i,
  output logic                 uart_txd_o,
  output logic                 tx_busy_o,
  output logic [FIFO_LOG2:0]   fifo_level_o,
  output logic                 overflow_o
);
  // state | meaning
  // IDLE  | line high, waiting for a queued nonce
  // START | start bit (line low)
  // DATA  | eight data bits of the current byte, LSB first
  // STOP  | stop bit (line high), then next byte or back to IDLE
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int DEPTH  = 1 << FIFO_LOG2;
  localparam int LVL_W  = FIFO_LOG2 + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);

  logic [31:0]          mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_full, pop, push;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           byte_q, byte_d;
  logic [31:0]          shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 baud_wrap;

  assign fifo_full = (level_q == FULL_LEVEL);
  assign pop       = (state_q == IDLE) && (level_q != '0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
  assign push      = golden_valid_i && (!fifo_full || pop);
  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    if (golden_valid_i && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wr_ptr_q] <= golden_nonce_i;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          byte_d  = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          txd_d   = shift_q[24];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            // The current byte always sits in bits [31:24]; bit k is at 24+k.
            txd_d = shift_q[{2'b11, bit_d}];
          end
        end
      end
      STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          if (byte_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            shift_d = {shift_q[23:0], 8'h00};
            txd_d   = 1'b0;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd_o   = txd_q;
  assign tx_busy_o    = (state_q != IDLE);
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Directed and random bench for golden_nonce_uart_tx with a bit-level UART receiver model.
module tb_golden_nonce_uart_tx;
  localparam int CPB   = 4;
  localparam int FL2   = 2;
  localparam int FRAME = 40 * CPB;

  logic          hash_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          golden_valid = 1'b0;
  logic [31:0]   golden_nonce = '0;
  logic          uart_txd, tx_busy, overflow;
  logic [FL2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [31:0] rx_q[$];

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
    .hash_clk       (hash_clk),
    .rst_n          (rst_n),
    .golden_valid_i (golden_valid),
    .golden_nonce_i (golden_nonce),
    .uart_txd_o     (uart_txd),
    .tx_busy_o      (tx_busy),
    .fifo_level_o   (fifo_level),
    .overflow_o     (overflow)
  );

  always #5 hash_clk = ~hash_clk;

  // Receiver: samples mid-bit (2 cycles into each 4-cycle bit) on falling edges.
  bit         rx_active = 0;
  int         rx_t = 0;
  int         rx_nbytes = 0;
  logic [7:0] rx_byte = '0;
  logic [31:0] rx_word = '0;
  always @(negedge hash_clk) begin
    if (!rst_n) begin
      rx_active = 0;
      rx_t      = 0;
      rx_nbytes = 0;
    end else if (!rx_active) begin
      if (uart_txd === 1'b0) begin
        rx_active = 1;
        rx_t      = 0;
      end
    end else begin
      rx_t++;
      if (rx_t == 2) begin
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("FAIL rx_start_bit got %b want 0", uart_txd); end
      end else if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 2) % 4) == 0) begin
        rx_byte[(rx_t - 6) / 4] = uart_txd;
      end else if (rx_t == 38) begin
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL rx_stop_bit got %b want 1", uart_txd); end
        rx_word = {rx_word[23:0], rx_byte};
        rx_nbytes++;
        if (rx_nbytes == 4) begin
          rx_q.push_back(rx_word);
          rx_nbytes = 0;
        end
        rx_active = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge hash_clk);
    rst_n = 1'b0;
    golden_valid = 1'b0;
    repeat (3) @(negedge hash_clk);
    rst_n = 1'b1;
    rx_q.delete();
  endtask

  // Called at a falling edge; leaves the strobe high across exactly one rising edge.
  task automatic strobe(input logic [31:0] n);
    golden_valid = 1'b1;
    golden_nonce = n;
    @(negedge hash_clk);
    golden_valid = 1'b0;
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!tx_busy && fifo_level == 0) begin ok = 1; break; end
      @(negedge hash_clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    golden_valid = 1'b1;
    golden_nonce = 32'h12345678;
    repeat (3) @(negedge hash_clk);
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_n = 1'b1;
    golden_valid = 1'b0;
    @(negedge hash_clk);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_valid_ignored level got %0d want 0", fifo_level); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_idle_txd got %b want 1", uart_txd); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    strobe(32'hDEADBEEF);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_queued level got %0d want 1", fifo_level); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL single_txd_E0 got %b want 1", uart_txd); end
    @(negedge hash_clk);
    checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL single_start_low got %b want 0", uart_txd); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_popped level got %0d want 0", fifo_level); end
    n = 1;
    for (int i = 0; i < 400 && tx_busy; i++) begin
      @(negedge hash_clk);
      if (tx_busy) n++;
    end
    checks++; if (n != FRAME) begin errors++; $display("FAIL single_busy_len got %0d want %0d", n, FRAME); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL single_idle_txd got %b want 1", uart_txd); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_rx count %0d first %h want 1 x deadbeef", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0);
    end
  endtask

  task automatic test_overflow();
    int peak;
    bit ok;
    do_reset();
    peak = 0;
    for (int i = 1; i <= 6; i++) begin
      golden_valid = 1'b1;
      golden_nonce = i;
      @(negedge hash_clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    golden_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (peak != 4) begin errors++; $display("FAIL ovf_peak got %0d want 4", peak); end
    wait_drained(6 * (FRAME + 1) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain timeout level %0d busy %b", fifo_level, tx_busy); end
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_rx_count got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 32'(i + 1)) begin errors++; $display("FAIL ovf_rx_order[%0d] got %h want %h", i, rx_q[i], 32'(i + 1)); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_reset got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    strobe(32'h00000000);
    repeat (29) @(negedge hash_clk);
    strobe(32'hFFFFFFFF);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL b2b_queued level got %0d want 1", fifo_level); end
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!tx_busy) begin ok = 1; break; end
      @(negedge hash_clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_frame1_end timeout busy %b", tx_busy); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL b2b_gap_txd got %b want 1", uart_txd); end
    @(negedge hash_clk);
    checks++; if (tx_busy !== 1'b1 || uart_txd !== 1'b0) begin errors++; $display("FAIL b2b_frame2_start busy %b txd %b want 1 0", tx_busy, uart_txd); end
    wait_drained(FRAME + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain timeout"); end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 32'h00000000 || rx_q[1] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL b2b_rx count %0d want 2 words 00000000 ffffffff", rx_q.size());
    end
  endtask

  task automatic test_full_pop_write();
    bit ok;
    logic [31:0] exp [6];
    exp = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005, 32'hF0000006};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      golden_valid = 1'b1;
      golden_nonce = exp[i];
      @(negedge hash_clk);
    end
    golden_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!tx_busy) begin ok = 1; break; end
      @(negedge hash_clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL full_wait_idle timeout"); end
    strobe(exp[5]);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_pop_write level got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_write overflow got %b want 0", overflow); end
    wait_drained(6 * (FRAME + 1) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain timeout"); end
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL full_rx_count got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL full_rx[%0d] got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      golden_valid = 1'b1;
      golden_nonce = (i == 0) ? 32'hA5005A5A : 32'h13579BDF + i;
      @(negedge hash_clk);
    end
    golden_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL arst_queued level got %0d want 2", fifo_level); end
    repeat (50) @(negedge hash_clk);
    checks++; if (tx_busy !== 1'b1 || uart_txd !== 1'b0) begin errors++; $display("FAIL arst_mid_data busy %b txd %b want 1 0", tx_busy, uart_txd); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL arst_txd got %b want 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b want 0", overflow); end
    repeat (3) @(negedge hash_clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge hash_clk);
      if (tx_busy !== 1'b0 || uart_txd !== 1'b1 || fifo_level !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL arst_no_frame_after active cycles %0d want 0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL arst_rx_count got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_random();
    int m_level, m_busy, mism, rx_bad;
    bit m_ovf, v, pop, acc;
    logic [31:0] n;
    logic [31:0] exp_q[$];
    do_reset();
    m_level = 0; m_busy = 0; m_ovf = 0; mism = 0;
    for (int cyc = 0; cyc < 22000; cyc++) begin
      if (int'(fifo_level) != m_level || tx_busy !== (m_busy != 0) || overflow !== m_ovf) mism++;
      v   = (cyc < 20000) && (((cyc / 2000) % 2) == 0) && ($urandom_range(0, 99) < 4);
      n   = $urandom();
      pop = (m_busy == 0) && (m_level != 0);
      acc = v && (m_level < 4 || pop);
      if (acc) exp_q.push_back(n);
      else if (v) m_ovf = 1;
      m_level = m_level + int'(acc) - int'(pop);
      if (pop) m_busy = FRAME;
      else if (m_busy > 0) m_busy--;
      golden_valid = v;
      golden_nonce = n;
      @(negedge hash_clk);
    end
    golden_valid = 1'b0;
    checks++; if (mism != 0) begin errors++; $display("FAIL rand_model_track mismatching cycles %0d want 0", mism); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_rx_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    rx_bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) rx_bad++;
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL rand_rx_stream wrong words %0d want 0", rx_bad); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow got %b want %b", overflow, m_ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_full_pop_write();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
